// File: rtl/rot_regfile_if.sv
// Bus between the rotary front end / LCD driver and rot_regfile: command
// entry signals in, rendered LCD lines and status out.
interface rot_regfile_if;
  logic         rot_event;
  logic [1:0]   mode;
  logic [3:0]   y;
  logic [127:0] first;
  logic [127:0] second;
  logic [3:0]   cnt;
  logic         busy;
  logic         done;

  modport master (
    output rot_event, mode, y,
    input  first, second, cnt, busy, done
  );

  modport slave (
    input  rot_event, mode, y,
    output first, second, cnt, busy, done
  );
endinterface

// File: rtl/rot_regfile.sv
// Register file commanded one field per rotary event (write, read-pair, add with carry);
// results are rendered as two 16-character ASCII lines for the LCD driver.
module rot_regfile #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16
) (
  input logic         clk,
  input logic         reset,
  rot_regfile_if.slave bus
);

  localparam int unsigned  ND        = DW / 4;
  localparam logic [1:0]   ModeWrite = 2'b00;
  localparam logic [1:0]   ModeAdd   = 2'b10;
  localparam logic [127:0] Blank     = {16{8'h20}};
  localparam logic [127:0] WriteOk   = {"WRITE OK", {8{8'h20}}};

  typedef enum logic [1:0] {StIdle, StField, StExec, StShow} state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   a_q, a_d, b_q, b_d, dst_q, dst_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   va_q, va_d, vb_q, vb_d;
  logic            carry_q, carry_d;
  logic [127:0]    first_q, first_d, second_q, second_d;
  logic [DW-1:0]   regs_q [NREGS];
  logic [DW-1:0]   regs_d [NREGS];
  logic [1:0]      mode_cur;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [127:0] put(input logic [127:0] line, input int unsigned pos,
                                       input logic [7:0] ch);
    logic [127:0] mask;
    mask = 128'hFF << (8 * (15 - pos));
    return (line & ~mask) | ({120'h0, ch} << (8 * (15 - pos)));
  endfunction

  // "R<a>=<DW/4 hex digits>", left aligned and space padded.
  function automatic logic [127:0] fmt_reg(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    logic [127:0] l;
    l = put(Blank, 0, 8'h52);
    l = put(l, 1, hex_char(4'(addr)));
    l = put(l, 2, 8'h3D);
    for (int unsigned i = 0; i < ND; i++) begin
      l = put(l, 3 + i, hex_char(4'(val >> (4 * (ND - 1 - i)))));
    end
    return l;
  endfunction

  function automatic logic [3:0] num_fields(input logic [1:0] m);
    case (m)
      ModeWrite: return 4'(1 + ND);
      ModeAdd:   return 4'd3;
      default:   return 4'd2;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    dst_d    = dst_q;
    data_d   = data_q;
    va_d     = va_q;
    vb_d     = vb_q;
    carry_d  = carry_q;
    first_d  = first_q;
    second_d = second_q;
    regs_d   = regs_q;
    // The mode is only taken from the bus on the first field of a command.
    mode_cur = (state_q == StIdle) ? bus.mode : mode_q;

    case (state_q)
      StIdle, StField: begin
        if (bus.rot_event) begin
          if (state_q == StIdle) begin
            mode_d = bus.mode;
            busy_d = 1'b1;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            a_d = bus.y[AW-1:0];
          end else if (mode_cur == ModeWrite) begin
            data_d = (data_q << 4) | DW'(bus.y);
          end else if (mode_cur == ModeAdd && cnt_q == 4'd2) begin
            dst_d = bus.y[AW-1:0];
          end else begin
            b_d = bus.y[AW-1:0];
          end
          state_d = (cnt_d == num_fields(mode_cur)) ? StExec : StField;
        end
      end
      StExec: begin
        // Sources come from regs_q, so a destination aliasing a source sees old data.
        case (mode_q)
          ModeWrite: begin
            regs_d[a_q] = data_q;
            va_d        = data_q;
          end
          ModeAdd: begin
            {carry_d, va_d} = {1'b0, regs_q[a_q]} + {1'b0, regs_q[b_q]};
            regs_d[dst_q]   = va_d;
          end
          default: begin
            va_d = regs_q[a_q];
            vb_d = regs_q[b_q];
          end
        endcase
        state_d = StShow;
      end
      StShow: begin
        case (mode_q)
          ModeWrite: begin
            first_d  = fmt_reg(a_q, va_q);
            second_d = WriteOk;
          end
          ModeAdd: begin
            first_d  = put(Blank, 0, 8'h52);
            first_d  = put(first_d, 1, hex_char(4'(a_q)));
            first_d  = put(first_d, 2, 8'h2B);
            first_d  = put(first_d, 3, 8'h52);
            first_d  = put(first_d, 4, hex_char(4'(b_q)));
            second_d = fmt_reg(dst_q, va_q);
            second_d = put(second_d, 4 + ND, 8'h43);
            second_d = put(second_d, 5 + ND, carry_q ? 8'h31 : 8'h30);
          end
          default: begin
            first_d  = fmt_reg(a_q, va_q);
            second_d = fmt_reg(b_q, vb_q);
          end
        endcase
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= 2'b00;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      carry_q  <= 1'b0;
      first_q  <= Blank;
      second_q <= Blank;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      carry_q  <= carry_d;
      first_q  <= first_d;
      second_q <= second_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.first  = first_q;
  assign bus.second = second_q;
  assign bus.cnt    = cnt_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_rot_regfile.sv
// Scoreboard bench for rot_regfile: a 16x16 instance and a 4x8 instance share clock and reset.
module tb_rot_regfile;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rot_regfile_if ifa ();
  rot_regfile_if ifb ();

  rot_regfile #(.NREGS(16), .AW(4), .DW(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  rot_regfile #(.NREGS(4),  .AW(2), .DW(8))  dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  typedef struct {
    bit              sel;
    logic [1:0]      m;
    int              nf;
    logic [8:0][3:0] f;
    int              gap;
  } cmd_t;

  typedef struct {
    logic [127:0] l1;
    logic [127:0] l2;
  } exp_t;

  exp_t         exp_q[$];
  logic [15:0]  mdl_a [16];
  logic [7:0]   mdl_b [4];
  int           n_vec = 0;
  int           n_bad = 0;
  localparam logic [127:0] Blank = {16{8'h20}};

  function automatic logic [127:0] to_line(input string s);
    logic [127:0] l;
    l = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) begin
      l = (l & ~(128'hFF << (8 * (15 - i)))) | ({120'h0, s[i]} << (8 * (15 - i)));
    end
    return l;
  endfunction

  function automatic logic [127:0] line16(input logic [3:0] a, input logic [15:0] v);
    string s;
    s = $sformatf("R%h=%h", a, v);
    return to_line(s.toupper());
  endfunction

  function automatic logic [127:0] line8(input logic [3:0] a, input logic [7:0] v);
    string s;
    s = $sformatf("R%h=%h", a, v);
    return to_line(s.toupper());
  endfunction

  function automatic logic [127:0] obs_first(input bit sel);
    return sel ? ifb.first : ifa.first;
  endfunction
  function automatic logic [127:0] obs_second(input bit sel);
    return sel ? ifb.second : ifa.second;
  endfunction
  function automatic logic obs_done(input bit sel);
    return sel ? ifb.done : ifa.done;
  endfunction
  function automatic logic obs_busy(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction
  function automatic logic [3:0] obs_cnt(input bit sel);
    return sel ? ifb.cnt : ifa.cnt;
  endfunction

  task automatic set_in(input bit sel, input logic ev, input logic [1:0] m, input logic [3:0] yv);
    if (sel) begin
      ifb.rot_event = ev; ifb.mode = m; ifb.y = yv;
    end else begin
      ifa.rot_event = ev; ifa.mode = m; ifa.y = yv;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b0, 1'b0, 2'b00, 4'h0);
    set_in(1'b1, 1'b0, 2'b00, 4'h0);
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    foreach (mdl_a[i]) mdl_a[i] = '0;
    foreach (mdl_b[i]) mdl_b[i] = '0;
    exp_q.delete();
  endtask

  // Drive all fields, then wait (bounded) for done; lat is cycles from the final event edge.
  task automatic run_cmd(input cmd_t c, input logic [1:0] m_alt, input bit extra, output int lat);
    for (int i = 0; i < c.nf; i++) begin
      @(negedge clk);
      set_in(c.sel, 1'b1, (i == 0) ? c.m : m_alt, c.f[i]);
      if (c.gap > 0 && i != c.nf - 1) begin
        @(negedge clk);
        set_in(c.sel, 1'b0, m_alt, 4'h0);
        repeat (c.gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    set_in(c.sel, extra, m_alt, 4'h5);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      set_in(c.sel, 1'b0, c.m, 4'h0);
      if (obs_done(c.sel)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic plan_write_a(input logic [3:0] a, input logic [15:0] v, input int gap,
                              output cmd_t c);
    c.sel = 1'b0; c.m = 2'b00; c.nf = 5; c.gap = gap; c.f = '0;
    c.f[0] = a;
    for (int i = 0; i < 4; i++) c.f[1 + i] = 4'(v >> (12 - 4 * i));
    mdl_a[a] = v;
    exp_q.push_back('{line16(a, v), to_line("WRITE OK")});
  endtask

  task automatic plan_read_a(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                             input int gap, output cmd_t c);
    c.sel = 1'b0; c.m = m; c.nf = 2; c.gap = gap; c.f = '0;
    c.f[0] = a; c.f[1] = b;
    exp_q.push_back('{line16(a, mdl_a[a]), line16(b, mdl_a[b])});
  endtask

  task automatic plan_add_a(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                            input int gap, output cmd_t c);
    logic [16:0] s;
    string t1, t2;
    c.sel = 1'b0; c.m = 2'b10; c.nf = 3; c.gap = gap; c.f = '0;
    c.f[0] = a; c.f[1] = b; c.f[2] = d;
    s  = {1'b0, mdl_a[a]} + {1'b0, mdl_a[b]};
    t1 = $sformatf("R%h+R%h", a, b);
    t2 = $sformatf("R%h=%h C%0d", d, s[15:0], s[16]);
    exp_q.push_back('{to_line(t1.toupper()), to_line(t2.toupper())});
    mdl_a[d] = s[15:0];
  endtask

  task automatic plan_write_b(input logic [3:0] ya, input logic [7:0] v, output cmd_t c);
    c.sel = 1'b1; c.m = 2'b00; c.nf = 3; c.gap = 1; c.f = '0;
    c.f[0] = ya; c.f[1] = v[7:4]; c.f[2] = v[3:0];
    mdl_b[ya[1:0]] = v;
    exp_q.push_back('{line8({2'b00, ya[1:0]}, v), to_line("WRITE OK")});
  endtask

  task automatic plan_read_b(input logic [3:0] ya, input logic [3:0] yb, output cmd_t c);
    c.sel = 1'b1; c.m = 2'b01; c.nf = 2; c.gap = 0; c.f = '0;
    c.f[0] = ya; c.f[1] = yb;
    exp_q.push_back('{line8({2'b00, ya[1:0]}, mdl_b[ya[1:0]]),
                      line8({2'b00, yb[1:0]}, mdl_b[yb[1:0]])});
  endtask

  task automatic test_reset();
    do_reset(2);
    repeat (5) @(negedge clk);
    n_vec++; if (ifa.first !== Blank) begin
      n_bad++; $display("FAIL reset first: got '%s' want blank", ifa.first); end
    n_vec++; if (ifa.second !== Blank) begin
      n_bad++; $display("FAIL reset second: got '%s' want blank", ifa.second); end
    n_vec++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
      n_bad++; $display("FAIL reset busy/done: got %b/%b want 0/0", ifa.busy, ifa.done); end
    n_vec++; if (ifa.cnt !== 4'd0) begin
      n_bad++; $display("FAIL reset cnt: got %0d want 0", ifa.cnt); end
    n_vec++; if (ifb.first !== Blank || ifb.second !== Blank) begin
      n_bad++; $display("FAIL reset small lines: got '%s' and '%s'", ifb.first, ifb.second); end
  endtask

  task automatic test_write();
    cmd_t c;
    exp_t e;
    int   lat;
    plan_write_a(4'h3, 16'h1234, 1, c);
    run_cmd(c, c.m, 1'b0, lat);
    e = exp_q.pop_front();
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL write latency: got %0d want 2", lat); end
    n_vec++; if (ifa.first !== e.l1) begin
      n_bad++; $display("FAIL write first: got '%s' want '%s'", ifa.first, e.l1); end
    n_vec++; if (ifa.second !== e.l2) begin
      n_bad++; $display("FAIL write second: got '%s' want '%s'", ifa.second, e.l2); end
    n_vec++; if (ifa.busy !== 1'b0 || ifa.cnt !== 4'd0) begin
      n_bad++; $display("FAIL write busy/cnt at done: got %b/%0d want 0/0", ifa.busy, ifa.cnt); end
    @(negedge clk);
    n_vec++; if (ifa.done !== 1'b0) begin
      n_bad++; $display("FAIL write done pulse: got %b want 0", ifa.done); end
  endtask

  // Mode flips to ADD after the first field and an extra event lands at E1; both are ignored.
  task automatic test_read();
    cmd_t c;
    exp_t e;
    int   lat;
    plan_read_a(2'b01, 4'h3, 4'h0, 1, c);
    run_cmd(c, 2'b10, 1'b1, lat);
    e = exp_q.pop_front();
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL read latency: got %0d want 2", lat); end
    n_vec++; if (ifa.first !== e.l1) begin
      n_bad++; $display("FAIL read first: got '%s' want '%s'", ifa.first, e.l1); end
    n_vec++; if (ifa.second !== e.l2) begin
      n_bad++; $display("FAIL read second: got '%s' want '%s'", ifa.second, e.l2); end
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (ifa.cnt !== 4'd0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
        n_bad++;
        $display("FAIL read dropped event: got cnt=%0d busy=%b done=%b want 0/0/0",
                 ifa.cnt, ifa.busy, ifa.done);
      end
    end
  endtask

  task automatic test_add_wrap();
    cmd_t cmds[$];
    cmd_t c;
    exp_t e;
    int   lat;
    plan_write_a(4'h1, 16'hFFFF, 0, c); cmds.push_back(c);
    plan_write_a(4'h2, 16'h0003, 0, c); cmds.push_back(c);
    plan_add_a(4'h1, 4'h2, 4'h1, 1, c); cmds.push_back(c);
    plan_read_a(2'b01, 4'h1, 4'h2, 1, c); cmds.push_back(c);
    foreach (cmds[i]) begin
      run_cmd(cmds[i], cmds[i].m, 1'b0, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== 2) begin
        n_bad++; $display("FAIL add[%0d] latency: got %0d want 2", i, lat); end
      n_vec++; if (ifa.first !== e.l1) begin
        n_bad++; $display("FAIL add[%0d] first: got '%s' want '%s'", i, ifa.first, e.l1); end
      n_vec++; if (ifa.second !== e.l2) begin
        n_bad++; $display("FAIL add[%0d] second: got '%s' want '%s'", i, ifa.second, e.l2);
      end
    end
  endtask

  // Fields in consecutive cycles, a destination aliasing both sources, and the reserved mode.
  task automatic test_back_to_back();
    cmd_t cmds[$];
    cmd_t c;
    exp_t e;
    int   lat;
    plan_write_a(4'h3, 16'h1234, 0, c); cmds.push_back(c);
    plan_add_a(4'h3, 4'h3, 4'h3, 0, c); cmds.push_back(c);
    plan_add_a(4'h3, 4'h1, 4'h7, 0, c); cmds.push_back(c);
    plan_read_a(2'b11, 4'h7, 4'h3, 0, c); cmds.push_back(c);
    foreach (cmds[i]) begin
      run_cmd(cmds[i], cmds[i].m, 1'b0, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== 2) begin
        n_bad++; $display("FAIL b2b[%0d] latency: got %0d want 2", i, lat); end
      n_vec++; if (ifa.first !== e.l1) begin
        n_bad++; $display("FAIL b2b[%0d] first: got '%s' want '%s'", i, ifa.first, e.l1); end
      n_vec++; if (ifa.second !== e.l2) begin
        n_bad++; $display("FAIL b2b[%0d] second: got '%s' want '%s'", i, ifa.second, e.l2);
      end
    end
  endtask

  task automatic test_abort();
    cmd_t cmds[$];
    cmd_t c;
    exp_t e;
    int   lat;
    @(negedge clk); set_in(1'b0, 1'b1, 2'b00, 4'h5);
    @(negedge clk); set_in(1'b0, 1'b1, 2'b00, 4'hA);
    @(negedge clk); set_in(1'b0, 1'b0, 2'b00, 4'h0);
    n_vec++; if (ifa.cnt !== 4'd2 || ifa.busy !== 1'b1) begin
      n_bad++; $display("FAIL abort mid cnt/busy: got %0d/%b want 2/1", ifa.cnt, ifa.busy); end
    do_reset(1);
    n_vec++; if (ifa.busy !== 1'b0 || ifa.cnt !== 4'd0) begin
      n_bad++; $display("FAIL abort busy/cnt: got %b/%0d want 0/0", ifa.busy, ifa.cnt); end
    n_vec++; if (ifa.first !== Blank || ifa.second !== Blank) begin
      n_bad++; $display("FAIL abort lines: got '%s' and '%s' want blank", ifa.first, ifa.second);
    end
    plan_read_a(2'b01, 4'h5, 4'h3, 1, c); cmds.push_back(c);
    plan_write_a(4'h5, 16'hBEEF, 2, c); cmds.push_back(c);
    plan_read_a(2'b01, 4'h5, 4'h3, 1, c); cmds.push_back(c);
    foreach (cmds[i]) begin
      run_cmd(cmds[i], cmds[i].m, 1'b0, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== 2) begin
        n_bad++; $display("FAIL abort[%0d] latency: got %0d want 2", i, lat); end
      n_vec++; if (ifa.first !== e.l1) begin
        n_bad++; $display("FAIL abort[%0d] first: got '%s' want '%s'", i, ifa.first, e.l1);
      end
      n_vec++; if (ifa.second !== e.l2) begin
        n_bad++; $display("FAIL abort[%0d] second: got '%s' want '%s'", i, ifa.second, e.l2);
      end
    end
  endtask

  task automatic test_sweep();
    cmd_t cmds[$];
    cmd_t c;
    exp_t e;
    int   lat;
    plan_write_b(4'hE, 8'hA5, c); cmds.push_back(c);
    plan_read_b(4'h2, 4'h6, c); cmds.push_back(c);
    plan_write_b(4'h1, 8'h3C, c); cmds.push_back(c);
    plan_read_b(4'h9, 4'hA, c); cmds.push_back(c);
    foreach (cmds[i]) begin
      run_cmd(cmds[i], cmds[i].m, 1'b0, lat);
      e = exp_q.pop_front();
      n_vec++; if (lat !== 2) begin
        n_bad++; $display("FAIL sweep[%0d] latency: got %0d want 2", i, lat); end
      n_vec++; if (ifb.first !== e.l1) begin
        n_bad++; $display("FAIL sweep[%0d] first: got '%s' want '%s'", i, ifb.first, e.l1);
      end
      n_vec++; if (ifb.second !== e.l2) begin
        n_bad++; $display("FAIL sweep[%0d] second: got '%s' want '%s'", i, ifb.second, e.l2);
      end
    end
    n_vec++; if (ifa.first !== obs_first(1'b0) || ifa.busy !== 1'b0) begin
      n_bad++; $display("FAIL sweep large busy: got %b want 0", ifa.busy); end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 2'b00, 4'h0);
    set_in(1'b1, 1'b0, 2'b00, 4'h0);
    test_reset();
    test_write();
    test_read();
    test_add_wrap();
    test_back_to_back();
    test_abort();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rot_regfile.md
# rot_regfile

Parametrised register file driven by the rotary-encoder event pulse and the 4-bit switch input `y`. It supports write, read-pair and add commands entered one field per rotary event, and renders the result as two 16-character ASCII lines (`first`, `second`) for the LCD driver. It sits between the rotary event detector and the LCD driver, and is the generalised successor of the fixed-size register block: configurable depth and width, command modes, and an add with carry.

## Interface
- `NREGS`, 16: number of registers; a power of two, 2..16.
- `AW`, 4: address width, equal to log2(NREGS).
- `DW`, 16: data width; a multiple of 4, 4..32.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `rot_event` input 1: one-cycle pulse per rotary detent.
- `mode` input 2: command select, sampled only at the first event of a command.
- `y` input 4: switch nibble, carrying an address (`y[AW-1:0]`) or a data nibble.
- `first` output 128: LCD line 1; character 0 is `[127:120]`.
- `second` output 128: LCD line 2; same character layout.
- `cnt` output 4: number of fields accepted in the current command.
- `busy` output 1: high from the first accepted event until `done`.
- `done` output 1: one-cycle pulse when the lines update.

## Operation
- Commands are entered one field per `rot_event`, in this order:
  - mode 00, WRITE: address A, then DW/4 data nibbles, MS nibble first.
  - mode 01, READ: address A, then address B.
  - mode 10, ADD: address A, then B, then destination D.
  - mode 11: reserved, executes as READ.
- States: IDLE → FIELD → EXEC → SHOW → IDLE.
  - IDLE: an event latches `mode` and the first field, sets `cnt`=1 and `busy`=1, and moves to FIELD. If the command has only one field it moves straight to EXEC; this cannot occur with the defined modes.
  - FIELD: each event latches the next field and increments `cnt`. The event that supplies the last field moves to EXEC.
  - EXEC: executes the command in a single cycle, then moves to SHOW.
    - WRITE: R[A] ← assembled word.
    - READ: latch R[A] and R[B].
    - ADD: {c, sum} = R[A] + R[B] at DW+1 bits; R[D] ← sum, which wraps modulo 2^DW.
    - Sources are read from pre-write contents, so D==A or D==B uses the old values.
  - SHOW: registers `first` and `second`, pulses `done`, clears `busy` and `cnt`, and returns to IDLE.
- Events arriving in EXEC or SHOW are ignored, not queued. Changes to `mode` after the first event are ignored.
- Bits of `y` above AW-1 are ignored for address fields.
- Line formats: hex digits are uppercase (0x30–0x39, 0x41–0x46). Values print as exactly DW/4 digits. Unused characters on the right are padded with 0x20.
  - WRITE: `first`="R"h(A)"="val(A new); `second`="WRITE OK".
  - READ: `first`="R"h(A)"="val(A); `second`="R"h(B)"="val(B).
  - ADD: `first`="R"h(A)"+R"h(B); `second`="R"h(D)"="sum" C"c, where c is "0" or "1".
  - Addresses print as one hex digit.
- Reset values:
  - All registers are 0.
  - `first` and `second` are all 0x20.
  - `cnt`=0, `busy`=0, `done`=0, state is IDLE.
- Reset mid-command aborts the command with no register write and forces the reset values. Reset wins over a simultaneous event.

## Timing
- Events are sampled on rising edges; an event is accepted only in IDLE or FIELD.
- Let E0 be the edge that samples the final field:
  - E1: the register write or latch occurs and the state becomes SHOW.
  - E2: `first`, `second` and `done`=1 update together, `busy`=0, and the state becomes IDLE.
  - E3: `done` returns to 0; an event sampled at E3 starts a new command.
- Latency from the final event to the display is 2 cycles. An event sampled at E1 or E2 is dropped.
- Back-to-back events in consecutive cycles are each accepted while in FIELD.
- `first` and `second` hold their values between `done` pulses.

## Test plan
- Reset, then idle for 5 cycles → `first` = `second` = 16×0x20; `busy`=0, `done`=0, `cnt`=0.
- WRITE with DW=16: events with y=3, then 1, 2, 3, 4 (mode=00) → R3=0x1234. `done` pulses 2 cycles after the 5th event; `first`="R3=1234", `second`="WRITE OK".
- READ: mode=01, events with y=3 then y=0 → `first`="R3=1234", `second`="R0=0000". An extra event sampled at E1 is ignored: `cnt` stays 0 and no new command starts.
- ADD wrap: preload R1=0xFFFF and R2=0x0003; mode=10, events with y=1, 2, 1 → R1=0x0002; `first`="R1+R2", `second`="R1=0002 C1".
- Mid-command abort: during WRITE, after 2 events assert `reset` for 1 cycle → the target register is unchanged at 0, lines are blank, `busy`=0. A full command afterwards works normally.
- Parameter sweep NREGS=4, DW=8: y=0xE as an address maps to R2. A WRITE takes 3 events. Values display as 2 hex digits.
